instr_fetch_unit: RTL and testbench

Instruction fetch stage of the DLX pipeline. It owns the program counter, drives the combinational-read instruction SRAM, and captures returned words into a 2-entry fetch queue. The queue feeds the decode stage through a valid/ready handshake. Branch/jump redirects flush the queue, and misaligned redirect targets trap into a fault state.

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// DLX instruction fetch stage: PC, combinational-read instruction SRAM port,
// and a 2-entry fetch queue feeding decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_cs,
  output logic        imem_oe,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  count;
  logic        fe;
  logic        pop;
  logic        misaligned;

  logic [31:0] tail_instr_p1;
  logic [31:0] tail_pc_p1;
  logic [31:0] tail_pc4_p1;

  assign pc_plus4   = pc + 32'd4;
  assign misaligned = (redirect_target[1:0] != 2'b00);
  assign id_valid   = (count != 2'd0);
  assign pop        = id_valid && id_ready;
  assign fe         = (state == FETCH) && !redirect_valid && ((count != 2'd2) || pop);

  assign imem_cs   = fe;
  assign imem_oe   = fe;
  assign imem_we   = 1'b0;
  assign imem_din  = 32'd0;
  assign imem_addr = pc;

  // Control: state machine and program counter; redirect outranks everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= {redirect_target[31:2], 2'b00};
      state       <= misaligned ? FAULT : FETCH;
      fetch_fault <= misaligned;
    end else begin
      case (state)
        BOOT: begin
          state       <= FETCH;
          fetch_fault <= 1'b0;
        end
        FETCH: begin
          if (fe) pc <= pc_plus4;
        end
        default: begin
          state       <= FAULT;
          fetch_fault <= 1'b1;
        end
      endcase
    end
  end

  // Stage p1: fetch queue; head entry drives id_* directly, tail is the second slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= 2'd0;
      id_instr      <= 32'd0;
      id_pc         <= 32'd0;
      id_pc_plus4   <= 32'd0;
      tail_instr_p1 <= 32'd0;
      tail_pc_p1    <= 32'd0;
      tail_pc4_p1   <= 32'd0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({fe, pop})
        2'b11: begin
          if (count == 2'd2) begin
            id_instr      <= tail_instr_p1;
            id_pc         <= tail_pc_p1;
            id_pc_plus4   <= tail_pc4_p1;
            tail_instr_p1 <= imem_dout;
            tail_pc_p1    <= pc;
            tail_pc4_p1   <= pc_plus4;
          end else begin
            id_instr    <= imem_dout;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
          end
        end
        2'b01: begin
          id_instr    <= tail_instr_p1;
          id_pc       <= tail_pc_p1;
          id_pc_plus4 <= tail_pc4_p1;
          count       <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            id_instr    <= imem_dout;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
          end else begin
            tail_instr_p1 <= imem_dout;
            tail_pc_p1    <= pc;
            tail_pc4_p1   <= pc_plus4;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random handshake/redirect
// traffic compared against a queue-based behavioural model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC   = 32'h00400000;
  localparam logic [31:0] RST_PC_B = 32'hFFFFFFF8;

  logic        clk;
  logic        rst_n;
  logic        imem_cs, imem_oe, imem_we;
  logic [31:0] imem_addr, imem_din, imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        fetch_fault;

  logic        cs_b, oe_b, we_b, vld_b, fault_b;
  logic [31:0] addr_b, din_b, dout_b, instr_b, pc_b, pc4_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_mode;  // 0 boot, 1 running, 2 faulted

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h00400020) return 32'h2001AAAA;
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  assign imem_dout = mem(imem_addr);
  assign dout_b    = mem(addr_b);

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_cs(imem_cs), .imem_oe(imem_oe), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_din(imem_din), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.RESET_PC(RST_PC_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_cs(cs_b), .imem_oe(oe_b), .imem_we(we_b),
    .imem_addr(addr_b), .imem_din(din_b), .imem_dout(dout_b),
    .redirect_valid(1'b0), .redirect_target(32'd0),
    .id_ready(1'b1), .id_valid(vld_b), .id_instr(instr_b),
    .id_pc(pc_b), .id_pc_plus4(pc4_b), .fetch_fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_fe;
    exp_fe = (m_mode == 1) && !redirect_valid && ((mq.size() < 2) || id_ready);
    chk("imem_cs", {31'd0, imem_cs}, {31'd0, exp_fe});
    chk("imem_oe", {31'd0, imem_oe}, {31'd0, exp_fe});
    chk("imem_we", {31'd0, imem_we}, 32'd0);
    chk("imem_din", imem_din, 32'd0);
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, mq.size() > 0});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_mode == 2});
    if (mq.size() > 0) begin
      chk("id_instr", id_instr, mq[0].instr);
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_pc_plus4", id_pc_plus4, mq[0].pc + 32'd4);
    end
    if (cyc < 5) begin
      chk("b_cs", {31'd0, cs_b}, {31'd0, cyc != 0});
      chk("b_addr", addr_b, (cyc == 0) ? RST_PC_B : RST_PC_B + 32'd4 * (cyc - 1));
    end
  endtask

  task automatic model_update(input logic rv, input logic [31:0] tgt, input logic rdy);
    logic fe;
    fe = (m_mode == 1) && !rv && ((mq.size() < 2) || rdy);
    if (rv) begin
      mq.delete();
      m_pc   = {tgt[31:2], 2'b00};
      m_mode = (tgt[1:0] == 2'b00) ? 1 : 2;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (fe) begin
        mq.push_back('{instr: mem(m_pc), pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
      if (m_mode == 0) m_mode = 1;
    end
  endtask

  // Called and returning on a falling edge.
  task automatic step(input logic rv, input logic [31:0] tgt, input logic rdy);
    redirect_valid  = rv;
    redirect_target = tgt;
    id_ready        = rdy;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(rv, tgt, rdy);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cs", {31'd0, imem_cs}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_b_addr", addr_b, RST_PC_B);
    mq.delete();
    m_pc   = RST_PC;
    m_mode = 0;
    cyc    = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    id_ready        = 1'b0;
    @(negedge clk);

    // Reset release with decode always ready
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    // Decode stalled from reset, then released
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1);

    // Full queue then redirect to an aligned target
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    step(1'b1, 32'h00400020, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1);

    // Misaligned redirect traps; aligned redirect recovers
    step(1'b1, 32'h00400022, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
    step(1'b1, 32'h00400024, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

    // Asynchronous reset with a full queue
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        t = 32'h00400000 + ($urandom_range(0, 255) << 2);
        if ($urandom_range(0, 3) == 0) t = t + $urandom_range(1, 3);
        step(1'b1, t, 1'($urandom_range(0, 1)));
      end else begin
        step(1'b0, 32'd0, 1'($urandom_range(0, 3) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
